// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: register offsets, bit positions
// and the serializer state encoding.
package uart_pkg;

  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV    = 2'd2;
  localparam logic [1:0] UART_CTRL   = 2'd3;

  localparam int STATUS_FULL      = 0;
  localparam int STATUS_EMPTY     = 1;
  localparam int STATUS_BUSY      = 2;
  localparam int STATUS_COUNT_LSB = 8;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO feeding the serializer. A push while full is
// rejected even if a pop happens in the same cycle.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FifoDepth = 8,
  localparam int PtrW = $clog2(FifoDepth),
  localparam int CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [7:0]      wdata_i,
  output logic [7:0]      rdata_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  logic [7:0]      mem_q [FifoDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(FifoDepth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Bus-attached 8N1 UART transmitter: register decode, registered bus response,
// TX FIFO and serializer FSM with a programmable bit time of DIV+1 cycles.
module uart_tx
  import uart_pkg::*;
#(
  parameter int          FifoDepth  = 8,
  parameter logic [15:0] DefaultDiv = 16'd867
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int CntW = $clog2(FifoDepth) + 1;

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [CntW-1:0] fifo_count;

  logic [15:0] div_cfg_q;
  logic        en_q, irq_en_q;
  logic        rvalid_q, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  uart_tx_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d, div_q, div_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d, irq_q;
  logic        start_ok, bit_end, busy;
  logic        wr, rd;
  logic [1:0]  reg_sel;

  logic unused_bits;
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], wdata_i[31:16], be_i[3:2]};

  uart_tx_fifo #(.FifoDepth(FifoDepth)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (wdata_i[7:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign reg_sel   = addr_i[3:2];
  assign wr        = req_i && we_i;
  assign rd        = req_i && !we_i;
  assign fifo_push = wr && (reg_sel == UART_TXDATA) && be_i[0];
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    rdata_d = '0;
    err_d   = fifo_push && fifo_full;
    if (rd) begin
      case (reg_sel)
        UART_STATUS: begin
          rdata_d[STATUS_FULL]                 = fifo_full;
          rdata_d[STATUS_EMPTY]                = fifo_empty;
          rdata_d[STATUS_BUSY]                 = busy;
          rdata_d[STATUS_COUNT_LSB +: CntW]    = fifo_count;
        end
        UART_DIV:  rdata_d[15:0] = div_cfg_q;
        UART_CTRL: begin
          rdata_d[CTRL_EN]     = en_q;
          rdata_d[CTRL_IRQ_EN] = irq_en_q;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      div_cfg_q <= DefaultDiv;
      en_q      <= 1'b0;
      irq_en_q  <= 1'b0;
    end else begin
      rvalid_q <= req_i;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      if (wr && reg_sel == UART_DIV) begin
        if (be_i[0]) div_cfg_q[7:0]  <= wdata_i[7:0];
        if (be_i[1]) div_cfg_q[15:8] <= wdata_i[15:8];
      end
      if (wr && reg_sel == UART_CTRL && be_i[0]) begin
        en_q     <= wdata_i[CTRL_EN];
        irq_en_q <= wdata_i[CTRL_IRQ_EN];
      end
    end
  end

  assign start_ok = en_q && !fifo_empty;
  assign bit_end  = (cnt_q == 16'd0);

  // Loading a new frame latches the divisor so DIV writes only affect later bytes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    div_d     = div_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d  = ST_START;
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          div_d    = div_cfg_q;
          cnt_d    = div_cfg_q;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          cnt_d     = div_q;
          bit_idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d     = div_q;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (start_ok) begin
            state_d  = ST_START;
            fifo_pop = 1'b1;
            shift_d  = fifo_rdata;
            div_d    = div_cfg_q;
            cnt_d    = div_cfg_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_START)     tx_d = 1'b0;
    else if (state_d == ST_DATA) tx_d = shift_d[0];
    else                         tx_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      div_q     <= '0;
      tx_q      <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      tx_q      <= tx_d;
      irq_q     <= irq_en_q && fifo_empty && (state_q == ST_IDLE);
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign tx_o     = tx_q;
  assign irq_o    = irq_q;

endmodule
